// File: rtl/seq_pattern_gen.sv
// Serial bit-pattern transmitter: shifts a parallel word out LSB-first, one bit per DIV clocks, with run tracking.
// Optional PRBS7 source enabled by defining SEQ_GEN_PRBS_EN (adds the prbs_mode input).
module seq_pattern_gen #(
  parameter int W       = 8,
  parameter int DIV     = 2,
  parameter int RUN_LEN = 4,
  localparam int LW     = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [W-1:0]  load_data,
  input  logic [LW-1:0] load_len,
`ifdef SEQ_GEN_PRBS_EN
  input  logic          prbs_mode,
`endif
  output logic          bit_out,
  output logic          bit_strobe,
  output logic          busy,
  output logic          done,
  output logic [3:0]    run_cnt,
  output logic          run_hit,
  output logic [1:0]    state_dbg
);

  // Handshake: a pattern transfers on a clock edge where load_valid && load_ready;
  // load_ready is high only in IDLE, so offers made during SHIFT/DONE are simply not taken.

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [3:0]    RUN_MAX  = 4'(RUN_LEN);
  localparam logic [LW-1:0] LEN_FULL = LW'(W);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  shreg_q, shreg_d;
  logic          bit_q, bit_d;
  logic          strobe_q, strobe_d;
  logic [DW-1:0] div_q, div_d;
  logic [LW-1:0] left_q, left_d;
  logic [3:0]    run_q, run_d;

  logic          accept;
  logic          period_end;
  logic          final_bit;
  logic          next_bit;
  logic [LW-1:0] len_eff;

`ifdef SEQ_GEN_PRBS_EN
  logic [6:0]    lfsr_q, lfsr_d;
  logic          prbs_q, prbs_d;
  logic [6:0]    seed;
`endif

  assign accept     = (state_q == ST_IDLE) && load_valid;
  assign period_end = (state_q == ST_SHIFT) && (div_q == DIV_LAST);
  assign final_bit  = (left_q == LW'(1));
  assign len_eff    = ((load_len == '0) || (load_len > LEN_FULL)) ? LEN_FULL : load_len;

`ifdef SEQ_GEN_PRBS_EN
  assign seed     = (load_data[6:0] == 7'd0) ? 7'h7F : load_data[6:0];
  assign next_bit = prbs_q ? lfsr_q[6] : shreg_q[0];
`else
  assign next_bit = shreg_q[0];
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (load_valid) state_d = ST_SHIFT;
      ST_SHIFT: if (period_end && final_bit) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: a new bit launches on accept or at the end of a non-final bit period
  always_comb begin
    shreg_d  = shreg_q;
    bit_d    = bit_q;
    strobe_d = 1'b0;
    div_d    = div_q;
    left_d   = left_q;
    run_d    = run_q;
`ifdef SEQ_GEN_PRBS_EN
    lfsr_d   = lfsr_q;
    prbs_d   = prbs_q;
`endif
    if (accept) begin
      left_d   = len_eff;
      div_d    = '0;
      strobe_d = 1'b1;
      run_d    = 4'd1;
      bit_d    = load_data[0];
      shreg_d  = load_data >> 1;
`ifdef SEQ_GEN_PRBS_EN
      prbs_d   = prbs_mode;
      if (prbs_mode) begin
        bit_d  = seed[6];
        lfsr_d = {seed[5:0], seed[6] ^ seed[5]};
      end
`endif
    end else if (state_q == ST_SHIFT) begin
      if (period_end) begin
        div_d = '0;
        if (!final_bit) begin
          left_d   = left_q - 1'b1;
          strobe_d = 1'b1;
          bit_d    = next_bit;
          shreg_d  = shreg_q >> 1;
`ifdef SEQ_GEN_PRBS_EN
          lfsr_d   = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
`endif
          if (next_bit == bit_q) begin
            run_d = (run_q >= RUN_MAX) ? RUN_MAX : run_q + 4'd1;
          end else begin
            run_d = 4'd1;
          end
        end
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q  <= '0;
      bit_q    <= 1'b0;
      strobe_q <= 1'b0;
      div_q    <= '0;
      left_q   <= '0;
      run_q    <= 4'd0;
`ifdef SEQ_GEN_PRBS_EN
      lfsr_q   <= 7'd0;
      prbs_q   <= 1'b0;
`endif
    end else begin
      shreg_q  <= shreg_d;
      bit_q    <= bit_d;
      strobe_q <= strobe_d;
      div_q    <= div_d;
      left_q   <= left_d;
      run_q    <= run_d;
`ifdef SEQ_GEN_PRBS_EN
      lfsr_q   <= lfsr_d;
      prbs_q   <= prbs_d;
`endif
    end
  end

  // Output logic
  always_comb begin
    load_ready = (state_q == ST_IDLE);
    busy       = (state_q == ST_SHIFT);
    done       = (state_q == ST_DONE);
    state_dbg  = state_q;
    bit_out    = bit_q;
    bit_strobe = strobe_q;
    run_cnt    = run_q;
    run_hit    = (run_q == RUN_MAX);
  end

endmodule
